// File: rtl/mp_out_stream.sv
// Output stream packer: collects IN_WIDTH-bit core words into BLOCK_BYTES-byte
// blocks across two ping-pong buffers and hands each block byte-by-byte to a
// UART transmitter. One buffer fills while the other one is being sent.
module mp_out_stream #(
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_data_in,
  input  logic                in_valid_in,
  output logic                in_ready_out,
  input  logic                flush_in,
  input  logic                tx_active_in,
  input  logic                tx_done_in,
  output logic [7:0]          tx_data_out,
  output logic                tx_dv_out,
  output logic                blk_done_out,
  output logic                busy_out
);

  localparam int unsigned BLOCK_BITS = BLOCK_BYTES * 8;
  localparam int unsigned WORDS      = BLOCK_BITS / IN_WIDTH;
  localparam int unsigned WCNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BCNT_W     = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } state_e;

  state_e                     state_q, state_d;
  logic [1:0][BLOCK_BITS-1:0] buf_q;
  logic [1:0]                 full_q, full_d;
  logic                       fill_sel_q, fill_sel_d;
  logic                       send_sel_q, send_sel_d;
  logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
  logic [BCNT_W-1:0]          bcnt_q, bcnt_d;
  logic                       tx_done_prev_q;
  logic                       accept;
  logic                       wr_en;
  logic                       done_rise;
  logic [BLOCK_BITS-1:0]      send_blk;
  logic [7:0]                 send_byte;

  assign in_ready_out = ~full_q[fill_sel_q];
  assign accept       = in_valid_in & in_ready_out;
  assign wr_en        = accept & ~flush_in;
  assign done_rise    = tx_done_in & ~tx_done_prev_q;
  assign busy_out     = (|full_q) | (wcnt_q != '0) | (state_q != S_IDLE);
  assign send_blk     = buf_q[send_sel_q];

  // Buffer storage: word slot 0 lands in the most significant bits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        if (wcnt_q == WCNT_W'(k)) begin
          buf_q[fill_sel_q][BLOCK_BITS-1-k*IN_WIDTH -: IN_WIDTH] <= in_data_in;
        end
      end
    end
  end

  // Select the byte currently addressed by bcnt in the outgoing buffer.
  always_comb begin
    send_byte = 8'h00;
    for (int unsigned b = 0; b < BLOCK_BYTES; b++) begin
      if (bcnt_q == BCNT_W'(b)) begin
        send_byte = MSB_FIRST ? send_blk[BLOCK_BITS-1-b*8 -: 8] : send_blk[b*8 +: 8];
      end
    end
  end

  // State, counters and buffer flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      full_q         <= 2'b00;
      fill_sel_q     <= 1'b0;
      send_sel_q     <= 1'b0;
      wcnt_q         <= '0;
      bcnt_q         <= '0;
      tx_done_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      full_q         <= full_d;
      fill_sel_q     <= fill_sel_d;
      send_sel_q     <= send_sel_d;
      wcnt_q         <= wcnt_d;
      bcnt_q         <= bcnt_d;
      tx_done_prev_q <= tx_done_in;
    end
  end

  // Fill-side bookkeeping, send FSM next state and outputs.
  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    fill_sel_d   = fill_sel_q;
    send_sel_d   = send_sel_q;
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
    tx_dv_out    = 1'b0;
    tx_data_out  = 8'h00;
    blk_done_out = 1'b0;

    // Flush wins over a same-cycle accept; completed buffers stay intact.
    if (flush_in) begin
      wcnt_d = '0;
    end else if (accept) begin
      if (wcnt_q == WCNT_LAST) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d         = ~fill_sel_q;
        wcnt_d             = '0;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[send_sel_q]) begin
          bcnt_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_data_out = send_byte;
        tx_dv_out   = ~tx_active_in;
        if (!tx_active_in) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tx_data_out = send_byte;
        if (done_rise) begin
          if (bcnt_q == BCNT_LAST) begin
            state_d = S_RELEASE;
          end else begin
            bcnt_d  = bcnt_q + BCNT_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_RELEASE: begin
        blk_done_out       = 1'b1;
        full_d[send_sel_q] = 1'b0;
        send_sel_d         = ~send_sel_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
